// File: rtl/bch_decode_correct_pkg.sv
// Shared width helpers for the BCH decode-correct slice.
package bch_decode_correct_pkg;

  // Width of a counter that has to hold the values 0..range_n-1 (never less than 1 bit).
  function automatic int cnt_width(input int range_n);
    return (range_n > 1) ? $clog2(range_n) : 1;
  endfunction

endpackage

// File: rtl/bch_pingpong_bank.sv
// Two K-bit message banks used ping-pong style. Each bank has a full flag.
// The write pointer and the read pointer advance independently of each other.
module bch_pingpong_bank
  import bch_decode_correct_pkg::*;
#(
  parameter int K  = 5,
  parameter int RW = cnt_width(K)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en,
  input  logic [RW-1:0] wr_idx,
  input  logic          wr_bit,
  input  logic          wr_done,
  input  logic [RW-1:0] rd_idx,
  input  logic          rd_done,
  output logic          wr_full,
  output logic          rd_full,
  output logic          rd_bit
);

  logic [K-1:0] bank [2];
  logic [1:0]   full;
  logic [1:0]   full_nxt;
  logic         wr_ptr;
  logic         rd_ptr;

  // Next full flags: the clear from a finished read is applied first, so a fill
  // completing on the same bank in the same cycle leaves that bank full.
  always_comb begin
    // NOTE: the default comes first so every path assigns full_nxt and no latch is inferred.
    full_nxt = full;
    if (rd_done) full_nxt[rd_ptr] = 1'b0;
    if (wr_done) full_nxt[wr_ptr] = 1'b1;
  end

  // Pointers and full flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: non-blocking assignments keep every flop updating from values sampled before the edge.
      full   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      full <= full_nxt;
      if (wr_done) wr_ptr <= ~wr_ptr;
      if (rd_done) rd_ptr <= ~rd_ptr;
    end
  end

  // Bank storage. A bank is read only while its full flag is set, so its contents never need a reset.
  always_ff @(posedge clk) begin
    // NOTE: the storage has no reset on purpose. The full flags qualify it, and resetting it would only add reset fan-out.
    if (wr_en) bank[wr_ptr][wr_idx] <= wr_bit;
  end

  assign wr_full = full[wr_ptr];
  assign rd_full = full[rd_ptr];
  assign rd_bit  = bank[rd_ptr][rd_idx];

endmodule

// File: rtl/bch_decode_correct.sv
// BCH correction stage.
// Takes serial codewords, keeps the K message bits in a ping-pong store,
// then XORs each stored bit with the Chien error-locator stream.
// It also counts the flips. The count saturates at T+1 to flag an uncorrectable word.
module bch_decode_correct
  import bch_decode_correct_pkg::*;
#(
  parameter int N = 15,
  parameter int K = 5,
  parameter int T = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   din,
  input  logic                   din_valid,
  input  logic                   din_first,
  input  logic                   err,
  input  logic                   err_valid,
  output logic                   dout,
  output logic                   dout_valid,
  output logic                   dout_last,
  output logic [$clog2(T+2)-1:0] err_count,
  output logic                   overflow
);

  localparam int WW = cnt_width(N);
  localparam int RW = cnt_width(K);
  localparam int EW = $clog2(T + 2);

  localparam logic [WW-1:0] K_W     = WW'(K);
  localparam logic [WW-1:0] N_LAST  = WW'(N - 1);
  localparam logic [RW-1:0] RD_LAST = RW'(K - 1);
  localparam logic [EW-1:0] EC_MAX  = EW'(T + 1);

  logic [WW-1:0] wr_cnt;
  logic [RW-1:0] rd_cnt;
  logic [EW-1:0] err_acc;
  logic [EW-1:0] acc_sum;
  logic [RW-1:0] wr_idx;
  logic          start, drop, cont;
  logic          wr_en, wr_done;
  logic          rd_go, rd_done;
  logic          wr_full, rd_full, rd_bit;

  // Write and read control decode.
  // A din_first that finds the write bank still full rejects the whole codeword.
  // wr_cnt stays at 0, so the rest of that codeword's bits are ignored as stray data.
  always_comb begin
    start   = din_valid && din_first && !wr_full;
    drop    = din_valid && din_first && wr_full;
    cont    = din_valid && !din_first && (wr_cnt != '0);
    wr_en   = start || (cont && (wr_cnt < K_W));
    wr_idx  = start ? '0 : wr_cnt[RW-1:0];
    wr_done = cont && (wr_cnt == N_LAST);
    rd_go   = err_valid && rd_full;
    rd_done = rd_go && (rd_cnt == RD_LAST);
    acc_sum = (err_acc == EC_MAX) ? EC_MAX : err_acc + EW'(err);
  end

  // Write counter and sticky overflow. Only reset clears overflow.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt   <= '0;
      overflow <= 1'b0;
    end else begin
      if (start)                wr_cnt <= WW'(1);
      else if (drop || wr_done) wr_cnt <= '0;
      else if (cont)            wr_cnt <= wr_cnt + WW'(1);
      if (drop) overflow <= 1'b1;
    end
  end

  // Read counter, corrected output bit and saturating error count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_cnt     <= '0;
      err_acc    <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      err_count  <= '0;
    end else begin
      dout_valid <= rd_go;
      dout_last  <= rd_done;
      if (rd_go) begin
        dout <= rd_bit ^ err;
        if (rd_done) begin
          rd_cnt    <= '0;
          err_acc   <= '0;
          err_count <= acc_sum;
        end else begin
          rd_cnt  <= rd_cnt + RW'(1);
          err_acc <= acc_sum;
        end
      end
    end
  end

  bch_pingpong_bank #(.K(K), .RW(RW)) u_bank (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_bit  (din),
    .wr_done (wr_done),
    .rd_idx  (rd_cnt),
    .rd_done (rd_done),
    .wr_full (wr_full),
    .rd_full (rd_full),
    .rd_bit  (rd_bit)
  );

endmodule

// File: tb/tb_bch_decode_correct.sv
// Scoreboard bench for bch_decode_correct (N=15, K=5, T=3).
// Drivers push the expected corrected bits when they issue an error burst.
// A negedge monitor pops one expectation per dout_valid and compares it.
module tb_bch_decode_correct;

  localparam int N  = 15;
  localparam int K  = 5;
  localparam int T  = 3;
  localparam int EW = $clog2(T + 2);

  typedef struct {
    logic b;
    logic last;
    int   cnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          din, din_valid, din_first;
  logic          err, err_valid;
  logic          dout, dout_valid, dout_last;
  logic [EW-1:0] err_count;
  logic          overflow;

  int            total = 0;
  int            bad   = 0;
  exp_t          exp_q[$];
  logic [K-1:0]  msg_q[$];
  int            occupied = 0;
  logic          exp_ovf  = 1'b0;

  bch_decode_correct #(.N(N), .K(K), .T(T)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .din        (din),
    .din_valid  (din_valid),
    .din_first  (din_first),
    .err        (err),
    .err_valid  (err_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_last  (dout_last),
    .err_count  (err_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_din(input int n);
    din_valid = 1'b0;
    din_first = 1'($urandom);
    repeat (n) @(negedge clk);
    din_first = 1'b0;
  endtask

  // Full codeword. The reference store holds at most two unread messages; a third is dropped.
  task automatic send_codeword(input logic [K-1:0] msg, input bit gaps);
    bit dropped;
    dropped = (occupied == 2);
    if (dropped) exp_ovf = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (gaps && i > 0 && $urandom_range(0, 3) == 0) idle_din($urandom_range(1, 2));
      din       = (i < K) ? msg[i] : 1'($urandom);
      din_first = (i == 0);
      din_valid = 1'b1;
      @(negedge clk);
    end
    din_valid = 1'b0;
    din_first = 1'b0;
    if (!dropped) begin
      msg_q.push_back(msg);
      occupied++;
    end
  endtask

  // Aborted prefix of len bits. It never completes, so nothing is stored.
  task automatic send_partial(input int len);
    if (occupied == 2) exp_ovf = 1'b1;
    for (int i = 0; i < len; i++) begin
      din       = 1'($urandom);
      din_first = (i == 0);
      din_valid = 1'b1;
      @(negedge clk);
    end
    din_valid = 1'b0;
    din_first = 1'b0;
  endtask

  // din_valid without din_first while idle: must be ignored.
  task automatic stray_bits(input int n);
    din_first = 1'b0;
    din_valid = 1'b1;
    repeat (n) begin
      din = 1'($urandom);
      @(negedge clk);
    end
    din_valid = 1'b0;
  endtask

  // Error burst for the oldest stored message. The expected output is msg XOR pattern,
  // and the flip count is the popcount of the pattern, capped at T+1.
  task automatic send_err(input logic [K-1:0] pat, input bit gaps);
    logic [K-1:0] m;
    exp_t         e;
    int           cnt;
    m   = msg_q.pop_front();
    cnt = $countones(pat);
    if (cnt > T + 1) cnt = T + 1;
    for (int i = 0; i < K; i++) begin
      e.b    = m[i] ^ pat[i];
      e.last = (i == K - 1);
      e.cnt  = cnt;
      exp_q.push_back(e);
    end
    for (int i = 0; i < K; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        err_valid = 1'b0;
        err       = 1'($urandom);
        repeat ($urandom_range(1, 2)) @(negedge clk);
      end
      err       = pat[i];
      err_valid = 1'b1;
      @(negedge clk);
    end
    err_valid = 1'b0;
    err       = 1'b0;
    occupied--;
  endtask

  // err_valid with nothing stored: must produce no output.
  task automatic stray_err();
    err       = 1'($urandom);
    err_valid = 1'b1;
    @(negedge clk);
    err_valid = 1'b0;
    err       = 1'b0;
  endtask

  // Monitor: one expectation per presented output; dout_last must stay low when dout_valid is low.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n === 1'b1) begin
      if (dout_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_output actual dout=%0b required=none at %0t", dout, $time);
        end else begin
          e = exp_q.pop_front();
          check("dout", dout, e.b);
          check("dout_last", dout_last, e.last);
          if (e.last) check("err_count", err_count, e.cnt);
        end
      end else begin
        check("dout_last_idle", dout_last, 1'b0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; din = 1'b0; din_valid = 1'b0; din_first = 1'b0;
    err = 1'b0; err_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dout", dout, 1'b0);
    check("rst_dout_valid", dout_valid, 1'b0);
    check("rst_dout_last", dout_last, 1'b0);
    check("rst_err_count", err_count, 0);
    check("rst_overflow", overflow, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);

    // Message 1,0,1,1,0 clean, then with errors at bits 1 and 4.
    send_codeword(5'b01101, 1'b0);
    send_err(5'b00000, 1'b0);
    send_codeword(5'b01101, 1'b1);
    send_err(5'b10010, 1'b0);
    repeat (3) @(negedge clk);

    // Three back-to-back codewords, with each error burst starting 20 cycles after its codeword.
    fork
      begin
        send_codeword(K'($urandom), 1'b0);
        send_codeword(K'($urandom), 1'b0);
        send_codeword(K'($urandom), 1'b0);
      end
      begin
        repeat (20) @(negedge clk);
        send_err(K'($urandom), 1'b0);
        repeat (10) @(negedge clk);
        send_err(K'($urandom), 1'b0);
        repeat (10) @(negedge clk);
        send_err(K'($urandom), 1'b0);
      end
    join
    repeat (3) @(negedge clk);
    check("overflow_streaming", overflow, 1'b0);

    // Three codewords with no reads: the third is dropped, and the first two survive.
    send_codeword(5'b10011, 1'b0);
    send_codeword(5'b01010, 1'b0);
    send_codeword(5'b11111, 1'b0);
    @(negedge clk);
    check("overflow_set", overflow, exp_ovf);
    send_err(5'b00000, 1'b0);
    send_err(5'b00000, 1'b0);
    repeat (3) @(negedge clk);

    // Randomized mix of codewords, aborted prefixes, stray bits and error bursts.
    for (int it = 0; it < 40; it++) begin
      int r;
      r = $urandom_range(0, 3);
      if (r < 2) begin
        if ($urandom_range(0, 3) == 0) stray_bits($urandom_range(1, 3));
        if ($urandom_range(0, 3) == 0) send_partial($urandom_range(2, N - 1));
        send_codeword(K'($urandom), 1'b1);
        @(negedge clk);
        check("overflow_rand", overflow, exp_ovf);
      end else if (occupied > 0) begin
        send_err(K'($urandom), 1'b1);
      end else begin
        stray_err();
      end
    end
    while (occupied > 0) send_err(K'($urandom), 1'b1);
    repeat (3) @(negedge clk);

    // All-ones error pattern on an all-zero message: the count saturates at T+1.
    send_codeword(5'b00000, 1'b1);
    send_err(5'b11111, 1'b0);
    repeat (3) @(negedge clk);
    check("err_count_hold", err_count, T + 1);

    // Reset in the middle of a codeword, with wr_cnt at 7.
    send_partial(7);
    reset_n = 1'b0;
    #1;
    check("mid_rst_dout", dout, 1'b0);
    check("mid_rst_dout_valid", dout_valid, 1'b0);
    check("mid_rst_dout_last", dout_last, 1'b0);
    check("mid_rst_err_count", err_count, 0);
    check("mid_rst_overflow", overflow, 1'b0);
    msg_q.delete();
    occupied = 0;
    exp_ovf  = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    send_codeword(5'b10110, 1'b0);
    send_err(5'b00100, 1'b0);
    repeat (5) @(negedge clk);
    check("overflow_after_rst", overflow, 1'b0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
